pipeline_stage_reg_elastic: RTL



---
 rtl/pipeline_stage_reg_elastic.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipeline_stage_reg_elastic.sv
// Elastic pipeline register chain with valid/ready backpressure,
// bubble collapsing, synchronous flush and occupancy count.
module pipeline_stage_reg_elastic #(
  parameter int DATA_W         = 32,
  parameter int CTRL_W         = 8,
  parameter int STAGES         = 1,
  parameter int ZERO_ON_BUBBLE = 1,
  localparam int OCC_W         = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  typedef struct packed {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;
  logic [STAGES-1:0] adv;
  stage_t            src [STAGES];

  // A stage advances when its successor advances or it holds a bubble.
  always_comb begin
    logic run;
    adv = '0;
    run = out_ready | ~st_q[STAGES-1].v;
    adv[STAGES-1] = run;
    for (int i = STAGES - 2; i >= 0; i--) begin
      run = run | ~st_q[i].v;
      adv[i] = run;
    end
  end

  assign in_ready = adv[0] & ~flush;

  always_comb begin
    src[0].v = in_valid;
    src[0].c = in_ctrl;
    src[0].d = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src[i] = st_q[i-1];
    end
  end

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        st_d[i].v = 1'b0;
        st_d[i].c = '0;
        if (ZERO_ON_BUBBLE != 0) begin
          st_d[i].d = '0;
        end
      end else if (adv[i]) begin
        st_d[i].v = src[i].v;
        if (src[i].v) begin
          st_d[i].c = src[i].c;
          st_d[i].d = src[i].d;
        end else begin
          st_d[i].c = '0;
          if (ZERO_ON_BUBBLE != 0) begin
            st_d[i].d = '0;
          end
        end
      end
    end
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(st_d[i].v);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        st_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      st_q  <= st_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid = st_q[STAGES-1].v;
  assign out_data  = st_q[STAGES-1].d;
  assign out_ctrl  = st_q[STAGES-1].c;
  assign occupancy = occ_q;

endmodule
